// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin arbiter driving a single-port sync RAM
// through a registered issue stage, with tagged read return and saturating grant counters.
module ram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  wr_rdn0,
    input  logic                  wr_rdn1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  ram_en,
    output logic                  ram_wr_rdn,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data_wr,
    input  logic [DATA_WIDTH-1:0] ram_data_rd,
    output logic [CNT_WIDTH-1:0]  gnt_cnt0,
    output logic [CNT_WIDTH-1:0]  gnt_cnt1
);
    logic ptr, tag0, tag1, acc;
    assign gnt0   = !rst && req0 && (!req1 || !ptr);
    assign gnt1   = !rst && req1 && (!req0 || ptr);
    assign acc    = gnt0 | gnt1;
    assign rdata0 = ram_data_rd;
    assign rdata1 = ram_data_rd;
    // tagN marks a read sitting in the issue register; rvalidN follows one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= 1'b0;
            ram_en      <= 1'b0;
            ram_wr_rdn  <= 1'b0;
            ram_addr    <= '0;
            ram_data_wr <= '0;
            tag0        <= 1'b0;
            tag1        <= 1'b0;
            rvalid0     <= 1'b0;
            rvalid1     <= 1'b0;
            gnt_cnt0    <= '0;
            gnt_cnt1    <= '0;
        end else begin
            ram_en  <= acc;
            tag0    <= gnt0 && !wr_rdn0;
            tag1    <= gnt1 && !wr_rdn1;
            rvalid0 <= tag0;
            rvalid1 <= tag1;
            if (acc) begin
                ptr         <= gnt0;
                ram_wr_rdn  <= gnt1 ? wr_rdn1 : wr_rdn0;
                ram_addr    <= gnt1 ? addr1 : addr0;
                ram_data_wr <= gnt1 ? wdata1 : wdata0;
            end
            if (gnt0 && gnt_cnt0 != '1) gnt_cnt0 <= gnt_cnt0 + CNT_WIDTH'(1);
            if (gnt1 && gnt_cnt1 != '1) gnt_cnt1 <= gnt_cnt1 + CNT_WIDTH'(1);
        end
    end
endmodule
